// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and consumer-side signals of uart_rx_fifo.
//   Rx_DATA/Rx_VALID/Rx_FERROR/Rx_PERROR : level outputs of uart_receiver
//   rd_en, clear_status                  : consumer requests
//   rd_data, rd_valid                    : registered read result
//   empty, full, count, overflow, err_count : FIFO status
//   master = stimulus/user side, slave = the FIFO itself
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4,
    parameter int ERR_W  = 8
);
    logic [7:0]        Rx_DATA;
    logic              Rx_VALID;
    logic              Rx_FERROR;
    logic              Rx_PERROR;
    logic              rd_en;
    logic              clear_status;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, rd_en, clear_status,
        input  rd_data, rd_valid, empty, full, count, overflow, err_count
    );

    modport slave (
        input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, rd_en, clear_status,
        output rd_data, rd_valid, empty, full, count, overflow, err_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: frame-detecting byte FIFO behind uart_receiver with error accounting.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : uart_rx_fifo_if.slave (receiver flags in, read handshake and status out)
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ERR_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_fifo_if.slave   bus
);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              ev_q, ev_d;
    logic              ev, frame, good, bad, empty, full, pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));

    // Receiver flags are levels; only their rising edge marks a new frame.
    assign ev    = bus.Rx_VALID | bus.Rx_FERROR | bus.Rx_PERROR;
    assign frame = ev & ~ev_q;
    assign good  = frame & bus.Rx_VALID & ~bus.Rx_FERROR & ~bus.Rx_PERROR;
    assign bad   = frame & (bus.Rx_FERROR | bus.Rx_PERROR);
    assign pop   = bus.rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push  = good & (~full | pop);
    assign drop  = good & full & ~pop;

    always_comb begin
        ev_d        = ev;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        rd_data_d   = pop ? mem[rd_ptr_q] : rd_data_q;
        rd_valid_d  = pop;
        overflow_d  = bus.clear_status ? 1'b0 : (overflow_q | drop);
        err_count_d = bus.clear_status ? '0 :
                      (bad && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            ev_q        <= ev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.Rx_DATA;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_rx_fifo_if #(.ADDR_W(4), .ERR_W(8)) bus();

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .ERR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input logic v, input logic f, input logic p);
        bus.Rx_DATA   = d;
        bus.Rx_VALID  = v;
        bus.Rx_FERROR = f;
        bus.Rx_PERROR = p;
        tick();
        bus.Rx_VALID  = 1'b0;
        bus.Rx_FERROR = 1'b0;
        bus.Rx_PERROR = 1'b0;
        tick();
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, int'(bus.rd_valid), 1);
        chk({tag, "_data"}, int'(bus.rd_data), int'(exp));
    endtask

    initial begin
        bus.Rx_DATA = 8'h00;
        bus.Rx_VALID = 1'b0;
        bus.Rx_FERROR = 1'b0;
        bus.Rx_PERROR = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear_status = 1'b0;
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_err", int'(bus.err_count), 0);
        tick();
        reset = 1'b0;
        tick();

        // Held Rx_VALID yields exactly one push, visible one clock later.
        bus.Rx_DATA = 8'hA5;
        bus.Rx_VALID = 1'b1;
        tick();
        chk("t1_count_lat", int'(bus.count), 1);
        chk("t1_empty_lat", int'(bus.empty), 0);
        repeat (19) tick();
        bus.Rx_VALID = 1'b0;
        tick();
        chk("t1_count_held", int'(bus.count), 1);
        rd("t1_rd", 8'hA5);
        chk("t1_count_after", int'(bus.count), 0);
        chk("t1_empty_after", int'(bus.empty), 1);
        tick();
        chk("t1_rd_valid_pulse", int'(bus.rd_valid), 0);

        // Bad frames: one carries Rx_VALID as well and must still be dropped.
        frame(8'h11, 1'b0, 1'b0, 1'b1);
        frame(8'h22, 1'b1, 1'b0, 1'b1);
        frame(8'h33, 1'b0, 1'b0, 1'b1);
        frame(8'hFF, 1'b0, 1'b1, 1'b0);
        frame(8'hFF, 1'b0, 1'b1, 1'b0);
        chk("t2_err", int'(bus.err_count), 5);
        chk("t2_count", int'(bus.count), 0);
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        chk("t2_err_clr", int'(bus.err_count), 0);

        // Fill, overflow, clear racing an overflow drop, then drain.
        for (int i = 0; i < 16; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
        chk("t3_full", int'(bus.full), 1);
        chk("t3_count", int'(bus.count), 16);
        frame(8'h10, 1'b1, 1'b0, 1'b0);
        chk("t3_overflow", int'(bus.overflow), 1);
        chk("t3_count_ovf", int'(bus.count), 16);
        bus.clear_status = 1'b1;
        frame(8'h11, 1'b1, 1'b0, 1'b0);
        bus.clear_status = 1'b0;
        chk("t3_ovf_clr_wins", int'(bus.overflow), 0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t3_drain_valid", int'(bus.rd_valid), 1);
            chk("t3_drain_data", int'(bus.rd_data), i);
        end
        tick();
        chk("t3_underflow_valid", int'(bus.rd_valid), 0);
        chk("t3_underflow_count", int'(bus.count), 0);
        bus.rd_en = 1'b0;
        chk("t3_empty", int'(bus.empty), 1);

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) frame(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
        bus.Rx_DATA = 8'h30;
        bus.Rx_VALID = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        bus.Rx_VALID = 1'b0;
        bus.rd_en = 1'b0;
        chk("t4_sim_valid", int'(bus.rd_valid), 1);
        chk("t4_sim_data", int'(bus.rd_data), 8'h20);
        chk("t4_sim_count", int'(bus.count), 16);
        chk("t4_sim_overflow", int'(bus.overflow), 0);
        tick();
        for (int i = 1; i < 16; i++) rd("t4_rd", 8'(8'h20 + i));
        rd("t4_rd_last", 8'h30);
        chk("t4_empty", int'(bus.empty), 1);

        // Push and pop together while empty: only the push lands.
        bus.Rx_DATA = 8'h40;
        bus.Rx_VALID = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        bus.Rx_VALID = 1'b0;
        bus.rd_en = 1'b0;
        chk("t4e_valid", int'(bus.rd_valid), 0);
        chk("t4e_count", int'(bus.count), 1);
        tick();
        rd("t4e_rd", 8'h40);

        // Clear racing a bad event.
        frame(8'hEE, 1'b0, 1'b1, 1'b0);
        chk("t4c_err1", int'(bus.err_count), 1);
        bus.Rx_FERROR = 1'b1;
        bus.clear_status = 1'b1;
        tick();
        bus.Rx_FERROR = 1'b0;
        bus.clear_status = 1'b0;
        chk("t4c_clr_wins", int'(bus.err_count), 0);
        tick();

        // Pointer wrap.
        for (int i = 0; i < 10; i++) frame(8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) rd("t5_rd_a", 8'(8'h50 + i));
        for (int i = 0; i < 10; i++) frame(8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
        chk("t5_count10", int'(bus.count), 10);
        for (int i = 0; i < 10; i++) rd("t5_rd_b", 8'(8'h60 + i));
        chk("t5_count0", int'(bus.count), 0);

        // Asynchronous reset mid-read.
        frame(8'hBB, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) frame(8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
        bus.rd_en = 1'b1;
        tick();
        chk("t6_pre_valid", int'(bus.rd_valid), 1);
        chk("t6_pre_err", int'(bus.err_count), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_count", int'(bus.count), 0);
        chk("t6_empty", int'(bus.empty), 1);
        chk("t6_rd_valid", int'(bus.rd_valid), 0);
        chk("t6_overflow", int'(bus.overflow), 0);
        chk("t6_err", int'(bus.err_count), 0);
        bus.rd_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_post_count", int'(bus.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
